vram_arbiter: RTL and testbench

- Shares one single-port video RAM between two requesters: the video scan-out fetch inside the Bocks display pipeline, and the HPS ioctl file-download writer.
- Video reads have absolute priority and a fixed latency.
- Download bytes are buffered in a small FIFO and written into RAM on cycles that video does not use.
- The block sits between hps_io/emu and the video RAM, with a download status FSM for the OSD/LED logic.

---
 rtl/vram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the video scan-out
// fetch and the ioctl download writer. Video reads always win the port and
// return data three cycles after the request. Download bytes wait in a small
// FIFO and are written on cycles that video leaves idle. A small FSM reports
// download progress for the OSD/LED logic.
//
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout  download byte stream from hps_io
//   vid_req, vid_addr       video read request
//   vid_valid, vid_data     video read return (3-cycle latency)
//   mem_addr/we/din, mem_dout   RAM port (outputs registered)
//   dl_busy, dl_done        download in progress / fully committed pulse
//   dl_overflow, dl_range_err   sticky drop flags for the current download
//   dl_count                bytes committed this download (saturating)
//
// state | meaning
// IDLE  | no download; FIFO empty
// LOAD  | download window open, bytes being accepted
// DRAIN | window closed, FIFO still emptying into RAM
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              dl_busy,
  output logic              dl_done,
  output logic              dl_overflow,
  output logic              dl_range_err,
  output logic [ADDR_W:0]   dl_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_next;
  logic              fifo_empty, fifo_full;
  logic              wr_strobe, in_range, push, pop;
  logic              range_drop, ovf_drop;
  logic              load_entry, done_c;
  logic [1:0]        vid_pipe;

  assign wr_strobe  = ioctl_wr & ioctl_download;
  assign in_range   = ((ioctl_addr >> ADDR_W) == 27'd0);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  // Video owns the port whenever it asks; the FIFO only drains on idle cycles.
  assign pop        = ~vid_req & ~fifo_empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push       = wr_strobe & in_range & (~fifo_full | pop);
  assign range_drop = wr_strobe & ~in_range;
  assign ovf_drop   = wr_strobe & in_range & fifo_full & ~pop;
  assign fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_next = state;
    load_entry = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ioctl_download) begin
          state_next = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          if (fifo_cnt_next != '0) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_IDLE;
            done_c     = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // A new window reopens LOAD without clearing the counters.
        if (ioctl_download) begin
          state_next = ST_LOAD;
        end else if (fifo_cnt_next == '0) begin
          state_next = ST_IDLE;
          done_c     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dl_busy = (state != ST_IDLE);
  assign dl_done = done_c & ~reset;

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr[ADDR_W-1:0];
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_din      <= '0;
      vid_pipe     <= '0;
      vid_valid    <= 1'b0;
      vid_data     <= '0;
      dl_count     <= '0;
      dl_overflow  <= 1'b0;
      dl_range_err <= 1'b0;
    end else begin
      state    <= state_next;
      fifo_cnt <= fifo_cnt_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (vid_req) begin
        mem_addr <= vid_addr;
        mem_we   <= 1'b0;
      end else if (pop) begin
        mem_addr <= fifo_addr[rd_ptr];
        mem_din  <= fifo_data[rd_ptr];
        mem_we   <= 1'b1;
      end else begin
        mem_we   <= 1'b0;
      end

      // Address goes out the cycle after the request, RAM data one cycle
      // later, and is registered once more for vid_data.
      vid_pipe  <= {vid_pipe[0], vid_req};
      vid_valid <= vid_pipe[1];
      if (vid_pipe[1]) vid_data <= mem_dout;

      if (load_entry) begin
        dl_count <= '0;
      end else if (pop && (dl_count != {(ADDR_W+1){1'b1}})) begin
        dl_count <= dl_count + 1'b1;
      end

      // Clear on a new download, but a drop in that same cycle still counts.
      if (load_entry) begin
        dl_overflow  <= 1'b0;
        dl_range_err <= 1'b0;
      end
      if (ovf_drop)   dl_overflow  <= 1'b1;
      if (range_drop) dl_range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [26:0]       ioctl_addr;
  logic [DATA_W-1:0] ioctl_dout;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              dl_busy;
  logic              dl_done;
  logic              dl_overflow;
  logic              dl_range_err;
  logic [ADDR_W:0]   dl_count;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .dl_busy(dl_busy), .dl_done(dl_done), .dl_overflow(dl_overflow),
    .dl_range_err(dl_range_err), .dl_count(dl_count)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 7) ^ (i >> 8) ^ 'h3C);
  endfunction

  // RAM model: synchronous read, data one cycle after the address.
  logic [7:0] ram [0:65535];
  bit         ram_written [0:65535];
  always @(posedge clk_sys) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr]         <= mem_din;
      ram_written[mem_addr] <= 1'b1;
    end
    mem_dout <= ram_written[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
  end

  typedef struct { logic [15:0] addr; logic [7:0] data; int due; } wr_exp_t;
  typedef struct { logic [7:0] data; int due; } rd_exp_t;

  wr_exp_t    wq[$];
  rd_exp_t    rq[$];
  logic [7:0] shadow [int];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_seen = 0;
  wr_exp_t wr_e;
  rd_exp_t rd_e;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard pop side: every write and video return is matched in order.
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      we_seen++;
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected cyc=%0d got addr=%h data=%h want no write", cyc, mem_addr, mem_din);
      end else begin
        wr_e = wq.pop_front();
        if (mem_addr !== wr_e.addr || mem_din !== wr_e.data || (wr_e.due >= 0 && cyc != wr_e.due)) begin
          bad++;
          $display("FAIL write_match got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   mem_addr, mem_din, cyc, wr_e.addr, wr_e.data, wr_e.due);
        end
      end
    end
    if (vid_valid === 1'b1) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL vid_unexpected cyc=%0d got data=%h want no valid", cyc, vid_data);
      end else begin
        rd_e = rq.pop_front();
        if (vid_data !== rd_e.data || cyc != rd_e.due) begin
          bad++;
          $display("FAIL vid_match got data=%h cyc=%0d want data=%h cyc=%0d", vid_data, cyc, rd_e.data, rd_e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] exp_rd(logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(int'(a));
  endfunction

  task automatic expect_wr(logic [15:0] a, logic [7:0] d, int due);
    wr_exp_t e;
    e.addr = a; e.data = d; e.due = due;
    wq.push_back(e);
    shadow[int'(a)] = d;
  endtask

  task automatic expect_rd(logic [15:0] a, int due);
    rd_exp_t e;
    e.data = exp_rd(a); e.due = due;
    rq.push_back(e);
  endtask

  task automatic strobe(logic [26:0] a, logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
  endtask

  function automatic logic [57:0] out_vec();
    return {vid_valid, vid_data, mem_addr, mem_we, mem_din, dl_busy, dl_done,
            dl_overflow, dl_range_err, dl_count};
  endfunction

  task automatic test_reset();
    int base;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; vid_req = 1'b0; vid_addr = '0;
    tick(); tick();
    total++;
    if (out_vec() !== 58'd0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", out_vec());
    end
    reset = 1'b0;
    base = we_seen;
    repeat (20) tick();
    total++;
    if (we_seen != base || dl_busy !== 1'b0) begin
      bad++; $display("FAIL idle_quiet got writes=%0d busy=%b want writes=0 busy=0", we_seen - base, dl_busy);
    end
  endtask

  task automatic test_download4();
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(27'(i), 8'(8'hA0 + i));
      expect_wr(16'(i), 8'(8'hA0 + i), cyc + 2);
      #1;
      total++;
      if (dl_done !== 1'b0) begin
        bad++; $display("FAIL dl4_done_early got %b want 0", dl_done);
      end
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    #1;
    total++;
    if (dl_done !== 1'b1 || dl_busy !== 1'b1) begin
      bad++; $display("FAIL dl4_done_pulse got done=%b busy=%b want done=1 busy=1", dl_done, dl_busy);
    end
    tick();
    total++;
    if (dl_done !== 1'b0 || dl_busy !== 1'b0 || dl_count !== 17'd4) begin
      bad++; $display("FAIL dl4_after got done=%b busy=%b count=%0d want done=0 busy=0 count=4", dl_done, dl_busy, dl_count);
    end
    tick(); tick();
    total++;
    if (wq.size() != 0) begin
      bad++; $display("FAIL dl4_writes_left got %0d want 0", wq.size());
    end
  endtask

  task automatic test_overflow();
    ioctl_download = 1'b1; vid_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vid_addr = 16'(16'h1000 + i);
      expect_rd(16'(16'h1000 + i), cyc + 3);
      if (i < 6) begin
        strobe(27'(27'h20 + i), 8'(8'hB0 + i));
        if (i < 4) expect_wr(16'(16'h20 + i), 8'(8'hB0 + i), -1);
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    vid_req = 1'b0; ioctl_wr = 1'b0;
    total++;
    if (dl_overflow !== 1'b1 || dl_range_err !== 1'b0 || dl_count !== 17'd0) begin
      bad++; $display("FAIL ovf_stalled got ovf=%b rerr=%b count=%0d want ovf=1 rerr=0 count=0", dl_overflow, dl_range_err, dl_count);
    end
    repeat (6) tick();
    total++;
    if (dl_count !== 17'd4 || wq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL ovf_drained got count=%0d wq=%0d rq=%0d want count=4 wq=0 rq=0", dl_count, wq.size(), rq.size());
    end
    ioctl_download = 1'b0;
    #1;
    total++;
    if (dl_done !== 1'b1) begin
      bad++; $display("FAIL ovf_done got %b want 1", dl_done);
    end
    tick();
    total++;
    if (dl_busy !== 1'b0 || dl_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got busy=%b ovf=%b want busy=0 ovf=1", dl_busy, dl_overflow);
    end
  endtask

  task automatic test_raw();
    ioctl_download = 1'b1;
    strobe(27'h10, 8'h5A);
    expect_wr(16'h0010, 8'h5A, cyc + 2);
    tick();
    ioctl_wr = 1'b0;
    tick();
    vid_req = 1'b1; vid_addr = 16'h0010;
    expect_rd(16'h0010, cyc + 3);
    tick();
    vid_req = 1'b0;
    repeat (4) tick();
    total++;
    if (rq.size() != 0 || vid_data !== 8'h5A) begin
      bad++; $display("FAIL raw_data got rq=%0d data=%h want rq=0 data=5a", rq.size(), vid_data);
    end
    ioctl_download = 1'b0;
    tick(); tick();
  endtask

  task automatic test_range();
    int base;
    ioctl_download = 1'b1;
    strobe(27'h30, 8'h11);
    expect_wr(16'h0030, 8'h11, cyc + 2);
    tick();
    strobe(27'h10000, 8'h77);
    tick();
    ioctl_wr = 1'b0;
    tick(); tick();
    total++;
    if (dl_range_err !== 1'b1 || dl_overflow !== 1'b0 || dl_count !== 17'd1) begin
      bad++; $display("FAIL range_flag got rerr=%b ovf=%b count=%0d want rerr=1 ovf=0 count=1", dl_range_err, dl_overflow, dl_count);
    end
    ioctl_download = 1'b0;
    tick(); tick();
    base = we_seen;
    strobe(27'h40, 8'h99);
    tick();
    ioctl_wr = 1'b0;
    repeat (3) tick();
    total++;
    if (we_seen != base || dl_range_err !== 1'b1) begin
      bad++; $display("FAIL range_idle got writes=%0d rerr=%b want writes=0 rerr=1", we_seen - base, dl_range_err);
    end
    ioctl_download = 1'b1;
    tick();
    total++;
    if (dl_range_err !== 1'b0 || dl_count !== 17'd0 || dl_busy !== 1'b1) begin
      bad++; $display("FAIL range_clear got rerr=%b count=%0d busy=%b want rerr=0 count=0 busy=1", dl_range_err, dl_count, dl_busy);
    end
    ioctl_download = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int base;
    ioctl_download = 1'b1;
    for (int i = 0; i < 2; i++) begin
      strobe(27'(27'h60 + i), 8'(8'hD0 + i));
      expect_wr(16'(16'h60 + i), 8'(8'hD0 + i), cyc + 2);
      tick();
    end
    ioctl_wr = 1'b0;
    tick(); tick();
    total++;
    if (dl_count !== 17'd2) begin
      bad++; $display("FAIL mid_count got %0d want 2", dl_count);
    end
    vid_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vid_addr = 16'(16'h2000 + i);
      // Only the first return lands before reset; the rest are flushed.
      if (i == 0) expect_rd(16'(16'h2000 + i), cyc + 3);
      strobe(27'(27'h50 + i), 8'(8'hC0 + i));
      tick();
    end
    ioctl_wr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; vid_req = 1'b0;
    #1;
    total++;
    if (out_vec() !== 58'd0) begin
      bad++; $display("FAIL mid_reset_outputs got %h want 0", out_vec());
    end
    tick();
    total++;
    if (dl_busy !== 1'b1 || dl_count !== 17'd0) begin
      bad++; $display("FAIL mid_reload got busy=%b count=%0d want busy=1 count=0", dl_busy, dl_count);
    end
    base = we_seen;
    repeat (10) tick();
    total++;
    if (we_seen != base || dl_count !== 17'd0) begin
      bad++; $display("FAIL mid_no_writes got writes=%0d count=%0d want writes=0 count=0", we_seen - base, dl_count);
    end
    ioctl_download = 1'b0;
    #1;
    total++;
    if (dl_done !== 1'b1) begin
      bad++; $display("FAIL mid_done got %b want 1", dl_done);
    end
    tick();
    total++;
    if (dl_busy !== 1'b0) begin
      bad++; $display("FAIL mid_idle got busy=%b want 0", dl_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_download4();
    test_overflow();
    test_raw();
    test_range();
    test_reset_mid();
    repeat (4) tick();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got wq=%0d rq=%0d want 0 0", wq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
